cnn_window_3x3_gen: RTL
=======================

# cnn_window_3x3_gen

Sliding-window generator that sits directly upstream of the 3x3 average-pooling stage. It accepts a raster-order pixel stream, one channel plane after another, and emits one 3x3 window per output position. The window is dilated by RATE and zero-padded at the image borders. Line storage is a single tapped shift register; an FSM inserts flush cycles at the end of each plane so that the output has the same size as the input.

## Interface
- DATA_WIDTH, 32: pixel width (IEEE-754 single; zero padding is 32'h0).
- IMAGE_WIDTH, 16: plane width W.
- IMAGE_HEIGHT, 16: plane height H.
- KERNEL, 3: must be 3; any other value is an elaboration error.
- RATE, 1: dilation R; requires 2R < min(W,H).
- CHANNEL_NUM_IN, 4: planes per frame.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  pixel_in valid; a pixel is accepted when valid_in && ready_in.
- pxl_in  in  DATA_WIDTH  raster-order pixel.
- ready_in  out  1  low only during flush.
- window_out  out  9*DATA_WIDTH  tap t=3i+j at [t*DATA_WIDTH +: DATA_WIDTH]; i = row (0 = top), j = column (0 = left).
- valid_out  out  1  window_out valid, one cycle per window; no downstream backpressure.
- last_out  out  1  asserted with the final window of the final channel.

## Operation
- Storage is a shift register of D = 2RW+2R+1 words. Every accepted pixel or flush cycle shifts it by one; flush cycles shift in 0.
- Tap (i,j) reads offset (2-i)RW + (2-j)R from the newest word. The window center is at offset L = RW+R.
- Counters:
  - in_idx (0..HW-1) and ch (0..CHANNEL_NUM_IN-1) track input pixels.
  - out_row and out_col track the current window center.
- Masking: tap (i,j) of center (r,c) sits at (r+(i-1)R, c+(j-1)R). If that position falls outside [0,H)x[0,W), the tap is forced to 0. This also hides stale words from the previous plane.
- FSM:
  - FILL: ready_in=1. Shifts with no output until L pixels of the plane are accepted, then goes to RUN.
  - RUN: ready_in=1. Every accepted pixel emits the window for the next center. After pixel HW-1 is accepted, goes to FLUSH.
  - FLUSH: ready_in=0. Performs L zero-shifts, each emitting a window. Then clears counters, increments ch (wrapping at CHANNEL_NUM_IN), and returns to FILL.
- Each plane yields exactly HW windows, in raster order.
- Cycles with valid_in=0 in FILL or RUN perform no shift and produce no output.
- Reset values:
  - state=FILL, all counters 0.
  - ready_in=1, valid_out=0, last_out=0, window_out=0.
  - The shift register is not reset.

## Timing
- Latency: the window for center index m appears on the cycle after the shift that brought in pixel index m+L, or the corresponding flush cycle. Outputs are registered.
- Plane throughput: HW+L cycles at full valid_in.
- Reset asserted mid-plane: all outputs return to reset values immediately (asynchronously), and the next accepted pixel is treated as ch0, index 0.
- A valid_in pulse during FLUSH is ignored, since ready_in=0. Upstream must hold the pixel until ready_in=1.

## Configuration
- CNN_WIN_3X3_PAD_EN defined: "same" mode, exactly as described above.
- CNN_WIN_3X3_PAD_EN undefined: "valid" mode.
  - No FLUSH state; ready_in is tied to 1.
  - Windows are emitted only for centers in [R,H-R)x[R,W-R), giving (H-2R)(W-2R) windows per plane.
  - Masking logic is removed.
  - Planes stream back-to-back.

## Structure
- Package cnn_pkg holds:
  - the FSM state enum (FILL, RUN, FLUSH);
  - the localparams D and L;
  - a tap-offset function (i,j,R,W).
- Sub-module cnn_tap_shift_reg: parameterised depth and width, with a shift enable and a zero-shift input. It exposes all 9 taps.

## Test plan
Default stimulus: W=H=16, R=1, C=4, macro defined, valid_in held high, pixel value = 1000*ch + idx + 1.
- Reset: hold reset=0 for 2 cycles, then release. Required: ready_in=1, valid_out=0, last_out=0, window_out=0.
- Top-left corner, ch0: the first window appears one cycle after value 18 is accepted, center (0,0). Required window = {0,0,0,0,1,2,0,17,18}.
- Interior, ch0: center (5,5). Required window = {69,70,71,85,86,87,101,102,103}.
- Flush, ch0:
  - After value 256 is accepted, ready_in=0 for exactly 17 cycles.
  - Center (15,15) window = {239,240,0,255,256,0,0,0,0}.
  - Each channel emits 256 windows.
  - The ch1 (0,0) window = {0,0,0,0,1001,1002,0,1017,1018}, with no ch0 leakage.
  - last_out fires only on window 1024.
- RATE=2, ch0 center (2,2): required window = {1,3,5,33,35,37,65,67,69}.
- Reset and mode coverage:
  - Assert reset at ch1 idx 100: valid_out drops within the same cycle. After release, the next corner window = {0,0,0,0,1,2,0,17,18}, treated as ch0 again.
  - Macro undefined: 196 windows per channel, first center (1,1) = {1,2,3,17,18,19,33,34,35}, ready_in never low.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the 3x3 dilated sliding-window generator.
package cnn_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned DEF_RATE  = 1;
  localparam int unsigned DEF_WIDTH = 16;

  // Line-store depth and center offset for the default geometry.
  localparam int unsigned D = 2 * DEF_RATE * DEF_WIDTH + 2 * DEF_RATE + 1;
  localparam int unsigned L = DEF_RATE * DEF_WIDTH + DEF_RATE;

  function automatic int unsigned cnn_depth(input int unsigned r, input int unsigned w);
    return 2 * r * w + 2 * r + 1;
  endfunction

  function automatic int unsigned cnn_center(input int unsigned r, input int unsigned w);
    return r * w + r;
  endfunction

  // Offset of tap (i,j) from the newest word in the shift register.
  function automatic int unsigned tap_offset(input int unsigned i, input int unsigned j,
                                             input int unsigned r, input int unsigned w);
    return (2 - i) * r * w + (2 - j) * r;
  endfunction

endpackage

// File: rtl/cnn_tap_shift_reg.sv
// Tapped line-store shift register; presents the 9 window taps as they will be after
// the current shift, so the registered window lines up with the shift that completes it.
module cnn_tap_shift_reg
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH       = 35,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RATE        = 1,
  parameter int unsigned IMAGE_WIDTH = 16
) (
  input  logic               clk,
  input  logic               shift_en,
  input  logic               zero_shift,
  input  logic [WIDTH-1:0]   din,
  output logic [9*WIDTH-1:0] taps
);

  if (DEPTH < cnn_depth(RATE, IMAGE_WIDTH)) begin : g_bad_depth
    $error("cnn_tap_shift_reg: DEPTH too small for RATE/IMAGE_WIDTH");
  end

  logic [WIDTH-1:0] sr [DEPTH];
  logic [WIDTH-1:0] incoming;

  assign incoming = zero_shift ? '0 : din;

  // Word 0 is the newest; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr[0] <= incoming;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  for (genvar t = 0; t < 9; t++) begin : g_tap
    localparam int unsigned OFF = tap_offset(int'(t / 3), int'(t % 3), RATE, IMAGE_WIDTH);
    if (OFF == 0) begin : g_new
      assign taps[t*WIDTH +: WIDTH] = incoming;
    end else begin : g_old
      assign taps[t*WIDTH +: WIDTH] = sr[OFF-1];
    end
  end

endmodule

// File: rtl/cnn_window_3x3_gen.sv
// 3x3 dilated sliding-window generator for a raster pixel stream, plane after plane.
// CNN_WIN_3X3_PAD_EN selects zero-padded "same" output with end-of-plane flush; otherwise "valid" mode.
module cnn_window_3x3_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IMAGE_WIDTH    = 16,
  parameter int unsigned IMAGE_HEIGHT   = 16,
  parameter int unsigned KERNEL         = 3,
  parameter int unsigned RATE           = 1,
  parameter int unsigned CHANNEL_NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   pxl_in,
  output logic                    ready_in,
  output logic [9*DATA_WIDTH-1:0] window_out,
  output logic                    valid_out,
  output logic                    last_out
);

  if (KERNEL != 3) begin : g_bad_kernel
    $error("cnn_window_3x3_gen: KERNEL must be 3");
  end
  if (2 * RATE >= IMAGE_WIDTH || 2 * RATE >= IMAGE_HEIGHT) begin : g_bad_rate
    $error("cnn_window_3x3_gen: 2*RATE must be below min(IMAGE_WIDTH, IMAGE_HEIGHT)");
  end

  localparam int unsigned HW     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned DEPTH  = cnn_depth(RATE, IMAGE_WIDTH);
  localparam int unsigned CENTER = cnn_center(RATE, IMAGE_WIDTH);
  localparam int unsigned IDX_W  = $clog2(HW);
  localparam int unsigned CH_W   = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int unsigned ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int unsigned COL_W  = $clog2(IMAGE_WIDTH);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        in_idx;
  logic [CH_W-1:0]         ch;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;
  logic                    accept, shift, zero_shift, advance, emit, plane_done, last_center;
  logic [9*DATA_WIDTH-1:0] taps, win_next;

  assign accept = valid_in && ready_in;

`ifdef CNN_WIN_3X3_PAD_EN
  localparam int unsigned FL_W = $clog2(CENTER);
  logic [FL_W-1:0] flush_cnt;

  assign ready_in = (state != FLUSH);
`else
  assign ready_in = 1'b1;
`endif

  always_comb begin
    state_n    = state;
    shift      = 1'b0;
    zero_shift = 1'b0;
    advance    = 1'b0;
    plane_done = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          shift = 1'b1;
          if (in_idx == IDX_W'(CENTER - 1)) state_n = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          shift   = 1'b1;
          advance = 1'b1;
          if (in_idx == IDX_W'(HW - 1)) begin
`ifdef CNN_WIN_3X3_PAD_EN
            state_n = FLUSH;
`else
            state_n    = FILL;
            plane_done = 1'b1;
`endif
          end
        end
      end
`ifdef CNN_WIN_3X3_PAD_EN
      FLUSH: begin
        shift      = 1'b1;
        zero_shift = 1'b1;
        advance    = 1'b1;
        if (flush_cnt == FL_W'(CENTER - 1)) begin
          state_n    = FILL;
          plane_done = 1'b1;
        end
      end
`endif
      default: state_n = FILL;
    endcase
  end

`ifdef CNN_WIN_3X3_PAD_EN
  assign emit        = advance;
  assign last_center = (ch == CH_W'(CHANNEL_NUM_IN - 1)) &&
                       (out_row == ROW_W'(IMAGE_HEIGHT - 1)) &&
                       (out_col == COL_W'(IMAGE_WIDTH - 1));

  // Zero every tap whose image position lies outside the plane; this also hides stale words.
  always_comb begin
    int row, col;
    win_next = taps;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        row = int'(out_row) + (int'(i) - 1) * int'(RATE);
        col = int'(out_col) + (int'(j) - 1) * int'(RATE);
        if (row < 0 || row >= int'(IMAGE_HEIGHT) || col < 0 || col >= int'(IMAGE_WIDTH)) begin
          win_next[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      flush_cnt <= (flush_cnt == FL_W'(CENTER - 1)) ? '0 : flush_cnt + 1'b1;
    end
  end
`else
  assign emit        = advance &&
                       (out_row >= ROW_W'(RATE)) && (out_row < ROW_W'(IMAGE_HEIGHT - RATE)) &&
                       (out_col >= COL_W'(RATE)) && (out_col < COL_W'(IMAGE_WIDTH - RATE));
  assign last_center = (ch == CH_W'(CHANNEL_NUM_IN - 1)) &&
                       (out_row == ROW_W'(IMAGE_HEIGHT - RATE - 1)) &&
                       (out_col == COL_W'(IMAGE_WIDTH - RATE - 1));
  assign win_next    = taps;
`endif

  cnn_tap_shift_reg #(
    .DEPTH      (DEPTH),
    .WIDTH      (DATA_WIDTH),
    .RATE       (RATE),
    .IMAGE_WIDTH(IMAGE_WIDTH)
  ) u_shift_reg (
    .clk       (clk),
    .shift_en  (shift),
    .zero_shift(zero_shift),
    .din       (pxl_in),
    .taps      (taps)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      in_idx     <= '0;
      ch         <= '0;
      out_row    <= '0;
      out_col    <= '0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      window_out <= '0;
    end else begin
      state <= state_n;
      if (plane_done) begin
        in_idx  <= '0;
        out_row <= '0;
        out_col <= '0;
        ch      <= (ch == CH_W'(CHANNEL_NUM_IN - 1)) ? '0 : ch + 1'b1;
      end else begin
        if (shift && !zero_shift) in_idx <= in_idx + 1'b1;
        if (advance) begin
          if (out_col == COL_W'(IMAGE_WIDTH - 1)) begin
            out_col <= '0;
            out_row <= out_row + 1'b1;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
      end
      valid_out <= emit;
      last_out  <= emit && last_center;
      if (emit) window_out <= win_next;
    end
  end

endmodule
